sb_pipe: RTL and testbench

SB_PIPE -- requirements
Module: sb_pipe

---
 rtl/sb_pkg.sv | 43 ++++
 rtl/sb_cfg_loader.sv | 128 ++++++++++++
 rtl/sb_pipe.sv | 79 +++++++
 tb/tb_sb_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared definitions for the switch-box pipeline: loader FSM states, selector
// codes and the layout of one track's 12-bit configuration field.
package sb_pkg;

    // Configuration loader states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StLoad = 2'd2,
        StSkip = 2'd3
    } cfg_state_e;

    // Selector codes: zero, or the next three sides clockwise from the output side
    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_CW1  = 2'd1;
    localparam logic [1:0] SEL_CW2  = 2'd2;
    localparam logic [1:0] SEL_CW3  = 2'd3;

    // Per-track field layout inside the configuration word
    localparam int unsigned TRACK_STRIDE = 12;
    localparam int unsigned OFF_SEL_N    = 0;
    localparam int unsigned OFF_SEL_E    = 2;
    localparam int unsigned OFF_SEL_S    = 4;
    localparam int unsigned OFF_SEL_W    = 6;
    localparam int unsigned OFF_REG_N    = 8;
    localparam int unsigned OFF_REG_E    = 9;
    localparam int unsigned OFF_REG_S    = 10;
    localparam int unsigned OFF_REG_W    = 11;

    // Four-way track mux; cw1..cw3 are the neighbouring sides in clockwise order
    function automatic logic route_mux(input logic [1:0] sel, input logic cw1,
                                       input logic cw2, input logic cw3);
        logic res;
        case (sel)
            SEL_CW1: res = cw1;
            SEL_CW2: res = cw2;
            SEL_CW3: res = cw3;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sb_cfg_loader.sv
// Serial configuration loader: passes the chain through with one cycle of
// delay, captures frames addressed to ID into a shadow register and commits
// them to the active register on the last payload bit.
module sb_cfg_loader #(
    parameter int unsigned CFG_SIZE = 192,
    parameter int unsigned ID_WIDTH = 3,
    parameter int unsigned ID       = 7
) (
    input  logic                clk,
    input  logic                crst,
    input  logic                cfg_in_start,
    input  logic                cfg_bit_in,
    output logic                cfg_out_start,
    output logic                cfg_bit_out,
    output logic                cfg_loaded,
    output logic [CFG_SIZE-1:0] cfg_active
);
    import sb_pkg::*;

    localparam int unsigned CNT_MAX = (ID_WIDTH > CFG_SIZE) ? ID_WIDTH : CFG_SIZE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]    HDR_LAST = CNT_W'(ID_WIDTH - 1);
    localparam logic [CNT_W-1:0]    PAY_LAST = CNT_W'(CFG_SIZE - 1);
    localparam logic [ID_WIDTH-1:0] MY_ID    = ID_WIDTH'(ID);
    localparam bit                  HDR_ONE  = (ID_WIDTH == 1);

    cfg_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ID_WIDTH-1:0] hdr_q;
    logic [CFG_SIZE-1:0] shadow_q;
    logic [CFG_SIZE-1:0] active_q;
    logic                loaded_q;
    logic                start_q;
    logic                bit_q;

    logic [ID_WIDTH:0]   hdr_shift;
    logic [ID_WIDTH-1:0] hdr_next;
    logic [CFG_SIZE-1:0] shadow_next;

    // Next header and shadow values with the current serial bit shifted in
    always_comb begin
        hdr_shift   = {hdr_q, cfg_bit_in};
        hdr_next    = hdr_shift[ID_WIDTH-1:0];
        shadow_next = {cfg_bit_in, shadow_q[CFG_SIZE-1:1]};
    end

    // Chain pass-through, unconditional for every instance
    always_ff @(posedge clk or posedge crst) begin
        if (crst) begin
            start_q <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            start_q <= cfg_in_start;
            bit_q   <= cfg_bit_in;
        end
    end

    // Loader FSM with bit counter, shadow and active registers
    always_ff @(posedge clk or posedge crst) begin
        if (crst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            hdr_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            loaded_q <= 1'b0;
        end else begin
            loaded_q <= 1'b0;
            if (cfg_in_start) begin
                // A start bit always begins a new header, aborting any frame in flight
                shadow_q <= '0;
                hdr_q    <= ID_WIDTH'(cfg_bit_in);
                if (HDR_ONE) begin
                    cnt_q   <= '0;
                    state_q <= (cfg_bit_in == MY_ID[0]) ? StLoad : StSkip;
                end else begin
                    cnt_q   <= CNT_W'(1);
                    state_q <= StHdr;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        cnt_q <= '0;
                    end
                    StHdr: begin
                        hdr_q <= hdr_next;
                        if (cnt_q == HDR_LAST) begin
                            cnt_q   <= '0;
                            state_q <= (hdr_next == MY_ID) ? StLoad : StSkip;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    StLoad: begin
                        shadow_q <= shadow_next;
                        if (cnt_q == PAY_LAST) begin
                            // Commit includes the bit sampled on this edge
                            active_q <= shadow_next;
                            loaded_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    StSkip: begin
                        if (cnt_q == PAY_LAST) begin
                            cnt_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign cfg_out_start = start_q;
    assign cfg_bit_out   = bit_q;
    assign cfg_loaded    = loaded_q;
    assign cfg_active    = active_q;

endmodule

// File: rtl/sb_pipe.sv
// Configurable switch box: each track output on each side selects one of the
// other three sides (or zero), optionally through a pipeline flop.
module sb_pipe #(
    parameter int unsigned CHN_WIDTH = 16,
    parameter int unsigned ID_WIDTH  = 3,
    parameter int unsigned ID        = 7
) (
    input  logic                 clk,
    input  logic                 crst,
    input  logic [CHN_WIDTH-1:0] north_in,
    input  logic [CHN_WIDTH-1:0] east_in,
    input  logic [CHN_WIDTH-1:0] south_in,
    input  logic [CHN_WIDTH-1:0] west_in,
    output logic [CHN_WIDTH-1:0] north_out,
    output logic [CHN_WIDTH-1:0] east_out,
    output logic [CHN_WIDTH-1:0] south_out,
    output logic [CHN_WIDTH-1:0] west_out,
    input  logic                 cfg_in_start,
    input  logic                 cfg_bit_in,
    output logic                 cfg_out_start,
    output logic                 cfg_bit_out,
    output logic                 cfg_loaded
);
    import sb_pkg::*;

    localparam int unsigned CFG_SIZE = TRACK_STRIDE * CHN_WIDTH;

    logic [CFG_SIZE-1:0] active_cfg;

    sb_cfg_loader #(
        .CFG_SIZE (CFG_SIZE),
        .ID_WIDTH (ID_WIDTH),
        .ID       (ID)
    ) u_loader (
        .clk           (clk),
        .crst          (crst),
        .cfg_in_start  (cfg_in_start),
        .cfg_bit_in    (cfg_bit_in),
        .cfg_out_start (cfg_out_start),
        .cfg_bit_out   (cfg_bit_out),
        .cfg_loaded    (cfg_loaded),
        .cfg_active    (active_cfg)
    );

    for (genvar i = 0; i < CHN_WIDTH; i++) begin : g_track
        logic [TRACK_STRIDE-1:0] cfg;
        logic                    mux_n;
        logic                    mux_e;
        logic                    mux_s;
        logic                    mux_w;
        logic [3:0]              pipe_q;  // {w, s, e, n}

        // Only the active register drives routing; the shadow is never visible here
        assign cfg = active_cfg[TRACK_STRIDE*i +: TRACK_STRIDE];

        // Source selection, clockwise from each output side
        always_comb begin
            mux_n = route_mux(cfg[OFF_SEL_N +: 2], east_in[i],  south_in[i], west_in[i]);
            mux_e = route_mux(cfg[OFF_SEL_E +: 2], south_in[i], west_in[i],  north_in[i]);
            mux_s = route_mux(cfg[OFF_SEL_S +: 2], west_in[i],  north_in[i], east_in[i]);
            mux_w = route_mux(cfg[OFF_SEL_W +: 2], north_in[i], east_in[i],  south_in[i]);
        end

        // Pipeline flops run every cycle; reg_X only picks which value is shown
        always_ff @(posedge clk or posedge crst) begin
            if (crst) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= {mux_w, mux_s, mux_e, mux_n};
            end
        end

        assign north_out[i] = cfg[OFF_REG_N] ? pipe_q[0] : mux_n;
        assign east_out[i]  = cfg[OFF_REG_E] ? pipe_q[1] : mux_e;
        assign south_out[i] = cfg[OFF_REG_S] ? pipe_q[2] : mux_s;
        assign west_out[i]  = cfg[OFF_REG_W] ? pipe_q[3] : mux_w;
    end

endmodule

// File: tb/tb_sb_pipe.sv
// Scoreboard bench for sb_pipe: stimulus queues expected observations keyed by
// sample cycle; a negedge monitor compares routing, chain delay and cfg_loaded.
module tb_sb_pipe;

    localparam int unsigned CHN_WIDTH = 2;
    localparam int unsigned ID_WIDTH  = 3;
    localparam int unsigned ID        = 5;

    logic       clk = 1'b0;
    logic       crst = 1'b0;
    logic [1:0] north_in = '0, east_in = '0, south_in = '0, west_in = '0;
    logic [1:0] north_out, east_out, south_out, west_out;
    logic       cfg_in_start = 1'b0, cfg_bit_in = 1'b0;
    logic       cfg_out_start, cfg_bit_out, cfg_loaded;

    sb_pipe #(
        .CHN_WIDTH (CHN_WIDTH),
        .ID_WIDTH  (ID_WIDTH),
        .ID        (ID)
    ) dut (
        .clk           (clk),
        .crst          (crst),
        .north_in      (north_in),
        .east_in       (east_in),
        .south_in      (south_in),
        .west_in       (west_in),
        .north_out     (north_out),
        .east_out      (east_out),
        .south_out     (south_out),
        .west_out      (west_out),
        .cfg_in_start  (cfg_in_start),
        .cfg_bit_in    (cfg_bit_in),
        .cfg_out_start (cfg_out_start),
        .cfg_bit_out   (cfg_bit_out),
        .cfg_loaded    (cfg_loaded)
    );

    always #5 clk = ~clk;

    // Observation word: {loaded, out_start, bit_out, west, south, east, north}
    logic [10:0] obs;
    assign obs = {cfg_loaded, cfg_out_start, cfg_bit_out, west_out, south_out, east_out, north_out};

    typedef struct {
        int unsigned at;
        string       name;
        logic [10:0] mask;
        logic [10:0] exp;
    } chk_t;

    chk_t        chk_q[$];
    int unsigned load_q[$];
    int unsigned neg_count = 0;
    int          n_total = 0;
    int          n_pass = 0;

    logic prev_start = 1'b0, prev_bit = 1'b0, prev_ok = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (sample %0d)", name, act, exp, neg_count);
    endtask

    task automatic expect_at(input int unsigned at, input string name,
                             input logic [10:0] mask, input logic [10:0] exp);
        chk_t c;
        c.at = at; c.name = name; c.mask = mask; c.exp = exp;
        chk_q.push_back(c);
    endtask

    // Record chain inputs as the DUT sees them on each edge
    always @(posedge clk) begin
        prev_start <= cfg_in_start;
        prev_bit   <= cfg_bit_in;
        prev_ok    <= !crst;
    end

    chk_t mon_c;
    int   mon_k;

    // Monitor: scoreboard pops, cfg_loaded model and chain delay, all at negedge
    always @(negedge clk) begin
        mon_k = 0;
        while (mon_k < chk_q.size()) begin
            if (chk_q[mon_k].at == neg_count) begin
                mon_c = chk_q[mon_k];
                check(mon_c.name, 32'(obs & mon_c.mask), 32'(mon_c.exp & mon_c.mask));
                chk_q.delete(mon_k);
            end else begin
                mon_k++;
            end
        end
        if (load_q.size() > 0 && load_q[0] == neg_count) begin
            check("cfg_loaded_pulse", 32'(cfg_loaded), 32'd1);
            void'(load_q.pop_front());
        end else begin
            check("cfg_loaded_quiet", 32'(cfg_loaded), 32'd0);
        end
        if (prev_ok && !crst) begin
            check("chain_start_delay", 32'(cfg_out_start), 32'(prev_start));
            check("chain_bit_delay", 32'(cfg_bit_out), 32'(prev_bit));
        end
        neg_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic s, input logic b);
        cfg_in_start = s;
        cfg_bit_in   = b;
        tick();
    endtask

    // Header MSB first, then the first npay payload bits LSB first
    task automatic send_bits(input logic [2:0] hdr, input logic [23:0] pay, input int npay);
        for (int k = 0; k < 3; k++) drive_bit(k == 0, hdr[2-k]);
        for (int k = 0; k < npay; k++) drive_bit(1'b0, pay[k]);
        cfg_in_start = 1'b0;
        cfg_bit_in   = 1'b0;
    endtask

    int unsigned n0, n1;
    logic [1:0]  east_vec [3];
    logic [1:0]  north_exp [3];
    logic [5:0]  tog;
    logic        prev_n1;

    initial begin
        // Reset with random activity on every input
        crst = 1'b1;
        tick();
        repeat (4) begin
            north_in     = 2'($urandom);
            east_in      = 2'($urandom);
            south_in     = 2'($urandom);
            west_in      = 2'($urandom);
            cfg_in_start = 1'($urandom);
            cfg_bit_in   = 1'($urandom);
            expect_at(neg_count, "reset_all_outputs", 11'h7FF, 11'h000);
            tick();
        end
        cfg_in_start = 1'b0;
        cfg_bit_in   = 1'b0;
        crst         = 1'b0;
        repeat (2) begin
            north_in = 2'($urandom);
            east_in  = 2'($urandom);
            south_in = 2'($urandom);
            west_in  = 2'($urandom);
            expect_at(neg_count, "post_reset_route_zero", 11'h0FF, 11'h000);
            tick();
        end

        // Load track 0 sel_n=1 (east), combinational
        north_in = 2'b00; east_in = 2'b01; south_in = 2'b00; west_in = 2'b00;
        tick();
        n0 = neg_count;
        expect_at(n0 + 26, "route_before_commit", 11'h0FF, 11'h000);
        load_q.push_back(n0 + 27);
        expect_at(n0 + 27, "route_on_commit", 11'h4FF, 11'h401);
        send_bits(3'b101, 24'h000001, 24);
        tick();
        east_vec[0] = 2'b10; north_exp[0] = 2'b00;
        east_vec[1] = 2'b11; north_exp[1] = 2'b01;
        east_vec[2] = 2'b01; north_exp[2] = 2'b01;
        for (int k = 0; k < 3; k++) begin
            east_in  = east_vec[k];
            north_in = 2'($urandom);
            south_in = 2'($urandom);
            west_in  = 2'($urandom);
            expect_at(neg_count, "north_from_east", 11'h0FF, {9'd0, north_exp[k]});
            tick();
        end

        // Track 1 reg_e=1, sel_e=3 (north); track 0 keeps sel_n=1
        north_in = 2'b00; east_in = 2'b01; south_in = 2'b00; west_in = 2'b00;
        tick();
        n0 = neg_count;
        expect_at(n0 + 26, "reg_before_commit", 11'h0FF, 11'h001);
        load_q.push_back(n0 + 27);
        expect_at(n0 + 27, "reg_on_commit", 11'h4FF, 11'h401);
        send_bits(3'b101, 24'h20C001, 24);
        tick();
        tog = 6'b011001;
        prev_n1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            north_in = {tog[k], 1'($urandom)};
            expect_at(neg_count, "east1_one_cycle_late", 11'h0FF,
                      11'h001 | (11'(prev_n1) << 3));
            tick();
            prev_n1 = tog[k];
        end
        north_in = 2'b00;
        expect_at(neg_count, "east1_final_follow", 11'h0FF, 11'h001 | (11'(prev_n1) << 3));
        tick();
        tick();

        // Mismatched header 011: routing frozen, no commit, chain still delays
        n0 = neg_count;
        for (int k = 0; k < 30; k++) expect_at(n0 + k, "skip_route_unchanged", 11'h0FF, 11'h001);
        send_bits(3'b011, 24'hFFFFFF, 24);
        repeat (3) tick();

        // Abort at payload bit 10, then a valid frame
        north_in = 2'b10; east_in = 2'b00; south_in = 2'b01; west_in = 2'b00;
        tick();
        tick();
        n0 = neg_count;
        n1 = n0 + 13;
        expect_at(n0 + 12, "abort_old_route", 11'h0FF, 11'h008);
        expect_at(n1 + 26, "abort_route_before_commit", 11'h0FF, 11'h008);
        load_q.push_back(n1 + 27);
        expect_at(n1 + 27, "abort_second_frame_route", 11'h4FF, 11'h481);
        send_bits(3'b101, 24'hFFFFFF, 10);
        send_bits(3'b101, 24'h040002, 24);
        tick();
        expect_at(neg_count, "abort_route_steady", 11'h0FF, 11'h081);
        tick();

        // Reset pulse at payload bit 20; tail bits must not commit
        send_bits(3'b101, 24'hFFFFFF, 20);
        crst = 1'b1;
        expect_at(neg_count, "midframe_reset_outputs", 11'h7FF, 11'h000);
        tick();
        crst = 1'b0;
        n0 = neg_count;
        for (int k = 0; k < 7; k++) expect_at(n0 + k, "midframe_reset_route_zero", 11'h0FF, 11'h000);
        for (int k = 20; k < 24; k++) drive_bit(1'b0, 1'b1);
        cfg_bit_in = 1'b0;
        repeat (3) tick();

        // Recovery: a fresh valid frame still commits
        n0 = neg_count;
        expect_at(n0 + 26, "recover_before_commit", 11'h0FF, 11'h000);
        load_q.push_back(n0 + 27);
        expect_at(n0 + 27, "recover_route", 11'h4FF, 11'h481);
        send_bits(3'b101, 24'h040002, 24);
        repeat (3) tick();

        check("scoreboard_drained", 32'(chk_q.size()), 32'd0);
        check("loads_drained", 32'(load_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
